oclib_csr_event_array: RTL and testbench



---
 rtl/oclib_csr_event_array.sv | 149 ++++++++++++++
 tb/tb_oclib_csr_event_array.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/oclib_csr_event_array.sv
// Event-capture CSR array: sticky W1C status, RW mask, per-channel event counters and a registered irq.
// Define OCLIB_CSR_EVENT_COUNT_EN to build the clear-on-read COUNT registers; otherwise COUNT reads 0.
module oclib_csr_event_array #(
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned EventW        = 8,
  parameter int unsigned CountW        = 16,
  parameter int unsigned CountSaturate = 1,
  parameter int unsigned AddrW         = 12
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          csrRead,
  input  logic                          csrWrite,
  input  logic [AddrW-1:0]              csrAddress,
  input  logic [31:0]                   csrWdata,
  output logic [31:0]                   csrRdata,
  output logic                          csrReady,
  output logic                          csrError,
  input  logic [NumChannels*EventW-1:0] events,
  output logic                          irq,
  output logic [NumChannels-1:0]        irqChannel
);

  localparam int unsigned WordW    = AddrW - 2;
  localparam int unsigned ChW      = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned NumWords = 4 * NumChannels;

  typedef logic [NumChannels-1:0][EventW-1:0] ev_arr_t;

  ev_arr_t                events_q;
  ev_arr_t                status_q, status_d;
  ev_arr_t                mask_q, mask_d;
  logic [NumChannels-1:0] irq_chan_q, irq_chan_d;
  logic [NumChannels-1:0] ch_sel;
  logic                   irq_q, irq_d;
  logic                   ready_q, error_q;
  logic [31:0]            rdata_q, rdata_d, rd_val;
  logic [WordW-1:0]       addr_word;
  logic [ChW-1:0]         chan_idx;
  logic [1:0]             reg_sel;
  logic                   accept, in_range, hit;
  logic                   unused_ok;

  assign addr_word = csrAddress[AddrW-1:2];
  assign chan_idx  = ChW'(addr_word >> 2);
  assign reg_sel   = addr_word[1:0];
  assign in_range  = 64'(addr_word) < 64'(NumWords);
  assign accept    = (csrRead | csrWrite) & ~ready_q;
  assign hit       = accept & in_range;

  // Byte-lane bits, upper write data and count config are intentionally unused in some builds.
  assign unused_ok = ^{csrAddress[1:0], csrWdata, 32'(CountW), 32'(CountSaturate)};

  always_comb begin
    ch_sel     = '0;
    irq_chan_d = '0;
    for (int c = 0; c < NumChannels; c++) begin
      ch_sel[c]     = hit && (chan_idx == ChW'(c));
      irq_chan_d[c] = |(status_q[c] & mask_q[c]);
    end
    irq_d = |irq_chan_d;
  end

`ifdef OCLIB_CSR_EVENT_COUNT_EN
  typedef logic [NumChannels-1:0][CountW-1:0] cnt_arr_t;

  cnt_arr_t          count_q, count_d;
  logic [CountW-1:0] cnt_base;

  // Clear-on-read drops the old value but keeps a same-cycle increment.
  always_comb begin
    count_d  = count_q;
    cnt_base = '0;
    for (int c = 0; c < NumChannels; c++) begin
      cnt_base = (ch_sel[c] && csrRead && (reg_sel == 2'd2)) ? '0 : count_q[c];
      if (|(events_q[c] & mask_q[c])) begin
        if ((CountSaturate != 0) && (&cnt_base)) count_d[c] = cnt_base;
        else                                     count_d[c] = cnt_base + CountW'(1);
      end else begin
        count_d[c] = cnt_base;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) count_q <= '0;
    else         count_q <= count_d;
  end
`endif

  // Register writes; event set is applied last so it wins over a same-cycle W1C.
  always_comb begin
    status_d = status_q;
    mask_d   = mask_q;
    for (int c = 0; c < NumChannels; c++) begin
      if (ch_sel[c] && csrWrite) begin
        case (reg_sel)
          2'd0:    status_d[c] = status_q[c] & ~csrWdata[EventW-1:0];
          2'd1:    mask_d[c]   = csrWdata[EventW-1:0];
          2'd3:    status_d[c] = status_q[c] | csrWdata[EventW-1:0];
          default: ;
        endcase
      end
      status_d[c] = status_d[c] | events_q[c];
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd0:    rd_val = 32'(status_q[chan_idx]);
      2'd1:    rd_val = 32'(mask_q[chan_idx]);
`ifdef OCLIB_CSR_EVENT_COUNT_EN
      2'd2:    rd_val = 32'(count_q[chan_idx]);
`endif
      default: rd_val = '0;
    endcase
    rdata_d = (hit && csrRead) ? rd_val : '0;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      events_q   <= '0;
      status_q   <= '0;
      mask_q     <= '0;
      irq_chan_q <= '0;
      irq_q      <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      events_q   <= events;
      status_q   <= status_d;
      mask_q     <= mask_d;
      irq_chan_q <= irq_chan_d;
      irq_q      <= irq_d;
      ready_q    <= accept;
      error_q    <= accept & ~in_range;
      rdata_q    <= rdata_d;
    end
  end

  assign csrRdata   = rdata_q;
  assign csrReady   = ready_q;
  assign csrError   = error_q;
  assign irq        = irq_q;
  assign irqChannel = irq_chan_q;

endmodule

// File: tb/tb_oclib_csr_event_array.sv
// Scoreboarded bench for oclib_csr_event_array: one default instance plus two 4-bit counter variants.
module tb_oclib_csr_event_array;

`ifdef OCLIB_CSR_EVENT_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] d_main;
    logic [31:0] d_sat;
    logic [31:0] d_wrap;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetN;
  logic        csrRead, csrWrite;
  logic [11:0] csrAddress;
  logic [31:0] csrWdata;
  logic [31:0] events;
  logic [31:0] csrRdata, rdata_s, rdata_w;
  logic        csrReady, ready_s, ready_w;
  logic        csrError, error_s, error_w;
  logic        irq, irq_s, irq_w;
  logic [3:0]  irqChannel, irqch_s, irqch_w;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic prev_ready = 1'b0;

  always #5 clock = ~clock;

  oclib_csr_event_array dut (
    .clock(clock), .resetN(resetN), .csrRead(csrRead), .csrWrite(csrWrite),
    .csrAddress(csrAddress), .csrWdata(csrWdata), .csrRdata(csrRdata),
    .csrReady(csrReady), .csrError(csrError), .events(events),
    .irq(irq), .irqChannel(irqChannel)
  );

  oclib_csr_event_array #(.CountW(4), .CountSaturate(1)) dut_sat (
    .clock(clock), .resetN(resetN), .csrRead(csrRead), .csrWrite(csrWrite),
    .csrAddress(csrAddress), .csrWdata(csrWdata), .csrRdata(rdata_s),
    .csrReady(ready_s), .csrError(error_s), .events(events),
    .irq(irq_s), .irqChannel(irqch_s)
  );

  oclib_csr_event_array #(.CountW(4), .CountSaturate(0)) dut_wrap (
    .clock(clock), .resetN(resetN), .csrRead(csrRead), .csrWrite(csrWrite),
    .csrAddress(csrAddress), .csrWdata(csrWdata), .csrRdata(rdata_w),
    .csrReady(ready_w), .csrError(error_w), .events(events),
    .irq(irq_w), .irqChannel(irqch_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt(input int v);
    return CntEn ? 32'(v) : 32'd0;
  endfunction

  // Issue one access, queue its expected response, wait (bounded) for csrReady.
  task automatic csr(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                     input logic [31:0] em, input logic [31:0] es, input logic [31:0] ew,
                     input bit eerr);
    exp_t e;
    bit   got;
    e.d_main = em; e.d_sat = es; e.d_wrap = ew; e.err = eerr;
    @(negedge clock);
    exp_q.push_back(e);
    csrAddress = addr;
    csrWdata   = wd;
    csrWrite   = wr;
    csrRead    = !wr;
    got        = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clock);
      #1;
      got = csrReady;
    end
    csrRead  = 1'b0;
    csrWrite = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL csr_timeout: no csrReady for addr 0x%03h", addr);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input bit eerr);
    csr(1'b0, addr, 32'd0, exp, exp, exp, eerr);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data, input bit eerr);
    csr(1'b1, addr, data, 32'd0, 32'd0, 32'd0, eerr);
  endtask

  // Monitor: pop and compare on every csrReady; rdata must be 0 otherwise.
  always @(negedge clock) begin
    exp_t e;
    if (resetN) begin
      if (csrReady) begin
        chk("ready_single_cycle", 32'(prev_ready), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: got csrReady with empty queue at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", csrRdata, e.d_main);
          chk("rdata_sat4", rdata_s, e.d_sat);
          chk("rdata_wrap4", rdata_w, e.d_wrap);
          chk("error", 32'(csrError), 32'(e.err));
        end
      end else begin
        chk("rdata_idle", csrRdata, 32'd0);
      end
    end
    prev_ready = csrReady;
  end

  initial begin
    resetN = 1'b0; csrRead = 1'b0; csrWrite = 1'b0;
    csrAddress = '0; csrWdata = '0; events = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rdata", csrRdata, 32'd0);
    chk("rst_ready", 32'(csrReady), 32'd0);
    chk("rst_error", 32'(csrError), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_irqch", 32'(irqChannel), 32'd0);
    @(negedge clock);
    resetN = 1'b1;

    for (int r = 0; r < 4; r++) rd(12'(r * 4), 32'd0, 1'b0);

    // Single event pulse on channel 1 bit 3
    wr(12'h014, 32'h08, 1'b0);
    @(negedge clock); events[11] = 1'b1;
    @(negedge clock); events[11] = 1'b0;
    chk("irq_edge_n", 32'(irq), 32'd0);
    @(negedge clock);
    chk("irq_edge_n1", 32'(irq), 32'd0);
    @(negedge clock);
    chk("irq_edge_n2", 32'(irq), 32'd1);
    chk("irqch_edge_n2", 32'(irqChannel), 32'h2);
    rd(12'h010, 32'h08, 1'b0);
    rd(12'h018, cnt(1), 1'b0);
    wr(12'h010, 32'h08, 1'b0);
    chk("irq_at_w1c_commit", 32'(irq), 32'd1);
    @(posedge clock); #1;
    chk("irq_after_w1c", 32'(irq), 32'd0);
    chk("irqch_after_w1c", 32'(irqChannel), 32'd0);

    // Held event beats W1C
    @(negedge clock); events[0] = 1'b1;
    repeat (3) @(negedge clock);
    wr(12'h000, 32'h01, 1'b0);
    rd(12'h000, 32'h01, 1'b0);
    events[0] = 1'b0;
    repeat (3) @(posedge clock);
    wr(12'h000, 32'h01, 1'b0);
    rd(12'h000, 32'h00, 1'b0);

    // Counters on channel 2
    wr(12'h024, 32'h01, 1'b0);
    rd(12'h028, 32'd0, 1'b0);
    @(negedge clock); events[16] = 1'b1;
    repeat (5) @(negedge clock);
    events[16] = 1'b0;
    repeat (3) @(posedge clock);
    rd(12'h028, cnt(5), 1'b0);
    rd(12'h028, 32'd0, 1'b0);
    @(negedge clock); events[16] = 1'b1;
    repeat (20) @(negedge clock);
    events[16] = 1'b0;
    repeat (3) @(posedge clock);
    csr(1'b0, 12'h028, 32'd0, cnt(20), cnt(15), cnt(4), 1'b0);
    rd(12'h028, 32'd0, 1'b0);
    // Increment coinciding with clear-on-read
    @(negedge clock); events[16] = 1'b1;
    rd(12'h028, 32'd0, 1'b0);
    events[16] = 1'b0;
    repeat (3) @(posedge clock);
    rd(12'h028, cnt(2), 1'b0);
    wr(12'h020, 32'h01, 1'b0);
    rd(12'h020, 32'h00, 1'b0);

    // Out-of-range accesses have no side effects
    rd(12'h100, 32'd0, 1'b1);
    wr(12'h104, 32'hFF, 1'b1);
    rd(12'h004, 32'd0, 1'b0);
    rd(12'h000, 32'd0, 1'b0);

    // FORCE on channel 3
    wr(12'h034, 32'hFF, 1'b0);
    wr(12'h03C, 32'hA5, 1'b0);
    rd(12'h030, 32'hA5, 1'b0);
    chk("irq_force", 32'(irq), 32'd1);
    chk("irqch_force", 32'(irqChannel), 32'h8);
    rd(12'h03C, 32'd0, 1'b0);
    rd(12'h038, 32'd0, 1'b0);
    wr(12'h034, 32'hFFFF_FF3C, 1'b0);
    rd(12'h034, 32'h3C, 1'b0);
    wr(12'h030, 32'hFF, 1'b0);
    rd(12'h030, 32'h00, 1'b0);
    repeat (2) @(posedge clock); #1;
    chk("irq_final", 32'(irq), 32'd0);

    repeat (4) @(posedge clock);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
